riscv_str_seq: RTL

Multi-word string sequencer placed upstream and downstream of riscv_str_ops in the EX stage.
- Takes a command (operator, word-aligned base address, byte length) and streams the buffer one 32-bit word at a time.
- For each word: reads it from the data memory port, presents it to riscv_str_ops, waits for that unit's ready, and writes the result back in place.
- Gives the core an in-place string transform without per-word software loops.

---
 rtl/riscv_defines.sv | 34 +++
 rtl/riscv_str_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_defines.sv
// Shared definitions for the string unit: operator codes, the sequencer
// state encoding and the last-word byte-enable helper.
package riscv_defines;

    localparam int STR_OP_WIDTH = 2;

    localparam logic [STR_OP_WIDTH-1:0] STR_UPPER = 2'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_LOWER = 2'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_ROT13 = 2'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_LEET  = 2'd3;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_RD_REQ  = 3'd1,
        SEQ_RD_WAIT = 3'd2,
        SEQ_EXEC    = 3'd3,
        SEQ_WR_REQ  = 3'd4,
        SEQ_WR_WAIT = 3'd5,
        SEQ_DONE    = 3'd6
    } str_seq_state_e;

    // Byte lanes for the final word; a remainder of 0 means a full word.
    function automatic logic [3:0] str_last_be(input logic [1:0] remaining);
        logic [3:0] be;
        case (remaining)
            2'd1:    be = 4'b0001;
            2'd2:    be = 4'b0011;
            2'd3:    be = 4'b0111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/riscv_str_seq.sv
// Multi-word string sequencer: walks a byte buffer one word at a time,
// feeds each word through riscv_str_ops and writes the result back in place.
module riscv_str_seq
    import riscv_defines::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [STR_OP_WIDTH-1:0] op_i,
    input  logic [31:0]             addr_i,
    input  logic [LEN_W-1:0]        len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    output logic [31:0]             data_addr_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [31:0]             data_wdata_o,
    input  logic [31:0]             data_rdata_i,
    output logic                    str_enable_o,
    output logic [STR_OP_WIDTH-1:0] str_operator_o,
    output logic [31:0]             str_operand_o,
    input  logic [31:0]             str_result_i,
    input  logic                    str_ready_i,
    output logic                    str_ex_ready_o
);

    localparam logic [LEN_W-1:0] WORD_BYTES = LEN_W'(4);

    str_seq_state_e          state_q, state_d;
    logic [STR_OP_WIDTH-1:0] op_q, op_d;
    logic [31:0]             addr_q, addr_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic [31:0]             operand_q, operand_d;
    logic [31:0]             result_q, result_d;
    logic                    exec_old_q, exec_old_d;
    logic                    busy_q, busy_d;

    logic                    last_word_s;
    logic [3:0]              wr_be_s;
    logic                    req_s, we_s, enable_s, ex_ready_s, done_s;
    logic [3:0]              be_s;

    assign last_word_s = (rem_q <= WORD_BYTES);
    assign wr_be_s     = last_word_s ? str_last_be(rem_q[1:0]) : 4'b1111;

    // Next-state, datapath updates and per-state output decode.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        operand_d  = operand_q;
        result_d   = result_q;
        exec_old_d = 1'b0;
        req_s      = 1'b0;
        we_s       = 1'b0;
        be_s       = 4'b0000;
        enable_s   = 1'b0;
        ex_ready_s = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start_i) begin
                    if (len_i != {LEN_W{1'b0}}) begin
                        op_d    = op_i;
                        addr_d  = addr_i & 32'hFFFF_FFFC;
                        rem_d   = len_i;
                        state_d = SEQ_RD_REQ;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_RD_REQ: begin
                req_s = 1'b1;
                be_s  = 4'b1111;
                if (data_gnt_i) begin
                    // A response in the grant cycle skips the wait state.
                    if (data_rvalid_i) begin
                        operand_d = data_rdata_i;
                        state_d   = SEQ_EXEC;
                    end else begin
                        state_d   = SEQ_RD_WAIT;
                    end
                end else begin
                    state_d = SEQ_RD_REQ;
                end
            end
            SEQ_RD_WAIT: begin
                if (data_rvalid_i) begin
                    operand_d = data_rdata_i;
                    state_d   = SEQ_EXEC;
                end else begin
                    state_d   = SEQ_RD_WAIT;
                end
            end
            SEQ_EXEC: begin
                enable_s = 1'b1;
                // Ignore ready in the first cycle: str_ops has not yet seen enable.
                if (exec_old_q && str_ready_i) begin
                    result_d   = str_result_i;
                    ex_ready_s = 1'b1;
                    state_d    = SEQ_WR_REQ;
                end else begin
                    exec_old_d = 1'b1;
                end
            end
            SEQ_WR_REQ: begin
                req_s = 1'b1;
                we_s  = 1'b1;
                be_s  = wr_be_s;
                if (data_gnt_i) begin
                    if (data_rvalid_i) begin
                        addr_d  = addr_q + 32'd4;
                        rem_d   = last_word_s ? {LEN_W{1'b0}} : (rem_q - WORD_BYTES);
                        state_d = last_word_s ? SEQ_DONE : SEQ_RD_REQ;
                    end else begin
                        state_d = SEQ_WR_WAIT;
                    end
                end else begin
                    state_d = SEQ_WR_REQ;
                end
            end
            SEQ_WR_WAIT: begin
                if (data_rvalid_i) begin
                    addr_d  = addr_q + 32'd4;
                    rem_d   = last_word_s ? {LEN_W{1'b0}} : (rem_q - WORD_BYTES);
                    state_d = last_word_s ? SEQ_DONE : SEQ_RD_REQ;
                end else begin
                    state_d = SEQ_WR_WAIT;
                end
            end
            SEQ_DONE: begin
                done_s  = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
        busy_d = (state_d != SEQ_IDLE);
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_IDLE;
            op_q       <= {STR_OP_WIDTH{1'b0}};
            addr_q     <= 32'd0;
            rem_q      <= {LEN_W{1'b0}};
            operand_q  <= 32'd0;
            result_q   <= 32'd0;
            exec_old_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            operand_q  <= operand_d;
            result_q   <= result_d;
            exec_old_q <= exec_old_d;
            busy_q     <= busy_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_s;
    assign data_req_o     = req_s;
    assign data_we_o      = we_s;
    assign data_be_o      = be_s;
    assign data_addr_o    = addr_q;
    assign data_wdata_o   = result_q;
    assign str_enable_o   = enable_s;
    assign str_operator_o = op_q;
    assign str_operand_o  = operand_q;
    assign str_ex_ready_o = ex_ready_s;

endmodule
